// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// byte-lane helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed lane of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (offset_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase
    lane_h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SZ_BYTE: data_o = {{(DATA_WIDTH-8){lane_b[7] & ~unsigned_i}}, lane_b};
      SZ_HALF: data_o = {{(DATA_WIDTH-16){lane_h[15] & ~unsigned_i}}, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between execute and writeback; issues one
// data-memory request per aligned access and reports faults without touching memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic                  in_store,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic                  in_opWrite,
  input  logic                  in_opSel,
  input  logic [4:0]            in_opReg,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  output logic                  opWrite,
  output logic                  opSel,
  output logic [4:0]            opReg,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic [DATA_WIDTH-1:0] memory_data,
  output logic                  misaligned
);

  logic [1:0]            state_q, state_d;
  logic                  store_q, unsigned_q, opwrite_q, opsel_q, mis_q;
  logic [1:0]            size_q;
  logic [4:0]            opreg_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q, alu_q, mdata_q, load_data;
  logic                  accept, in_mis, in_mem_op;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  unused_core;

  assign unused_core = ^CORE;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid & in_ready;
  assign in_mem_op = in_load | in_store;
  // Pass-through ops never fault, whatever their size field holds.
  assign in_mis    = in_mem_op & is_misaligned(in_size, in_addr[1:0]);

  always_comb begin
    case (in_size)
      SZ_BYTE: in_wdata = {(DATA_WIDTH/8){in_store_data[7:0]}};
      SZ_HALF: in_wdata = {(DATA_WIDTH/16){in_store_data[15:0]}};
      default: in_wdata = in_store_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = (in_mem_op && !in_mis) ? StReq : StDone;
      StReq:  if (mem_gnt) state_d = store_q ? StDone : StWait;
      StWait: if (mem_rvalid) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  mem_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .rdata_i   (mem_rdata),
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .data_o    (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      opwrite_q  <= 1'b0;
      opsel_q    <= 1'b0;
      mis_q      <= 1'b0;
      size_q     <= 2'b00;
      opreg_q    <= 5'd0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      alu_q      <= '0;
      mdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // A simultaneous load+store is executed as a store.
        store_q    <= in_store;
        unsigned_q <= in_unsigned;
        opwrite_q  <= in_opWrite;
        opsel_q    <= in_opSel;
        mis_q      <= in_mis;
        size_q     <= in_size;
        opreg_q    <= in_opReg;
        addr_q     <= in_addr;
        be_q       <= byte_enables(in_size, in_addr[1:0]);
        wdata_q    <= in_wdata;
        alu_q      <= DATA_WIDTH'(in_addr);
        mdata_q    <= '0;
      end
      if (state_q == StWait && mem_rvalid) begin
        mdata_q <= load_data;
      end
    end
  end

  assign mem_req     = (state_q == StReq);
  assign mem_we      = mem_req & store_q;
  assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign out_valid   = (state_q == StDone);
  assign opWrite     = opwrite_q & out_valid & ~mis_q;
  assign misaligned  = mis_q & out_valid;
  assign opSel       = opsel_q;
  assign opReg       = opreg_q;
  assign ALU_result  = alu_q;
  assign memory_data = mdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard of
// writeback results, and hand-written reset and back-to-back sequences.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_load, in_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_store_data;
  logic        in_opWrite, in_opSel;
  logic [4:0]  in_opReg;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        out_valid, opWrite, opSel, misaligned;
  logic [4:0]  opReg;
  logic [31:0] ALU_result, memory_data;

  always #5 clock = ~clock;

  mem_access_unit #(
    .CORE      (0),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_store_data(in_store_data),
    .in_opWrite   (in_opWrite),
    .in_opSel     (in_opSel),
    .in_opReg     (in_opReg),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .opWrite      (opWrite),
    .opSel        (opSel),
    .opReg        (opReg),
    .ALU_result   (ALU_result),
    .memory_data  (memory_data),
    .misaligned   (misaligned)
  );

  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, sdata, rdata;
    logic        opw;
    logic [4:0]  rd;
    int          gdly;
    logic [3:0]  be;
    logic [31:0] wdata, mdata;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] mdata;
    logic        opw;
    logic        mis;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int gdly, input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] mdata, input logic mis);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.sdata = sdata;
    v.rdata = rdata; v.opw = 1'b1; v.rd = addr[6:2]; v.gdly = gdly; v.be = be;
    v.wdata = wdata; v.mdata = mdata; v.mis = mis;
    return v;
  endfunction

  // Writeback monitor: every out_valid pulse must match the oldest accepted op.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        chk("out_valid_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("memory_data", memory_data, mon_e.mdata);
          chk("opWrite", {31'd0, opWrite}, {31'd0, mon_e.opw});
          chk("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
          chk("ALU_result", ALU_result, mon_e.alu);
          chk("opReg", {27'd0, opReg}, {27'd0, mon_e.rd});
        end
      end else begin
        chk("opWrite_idle", {31'd0, opWrite}, 32'd0);
        chk("misaligned_idle", {31'd0, misaligned}, 32'd0);
      end
    end
  end

  task automatic do_vec(input vec_t v, input int idx);
    int   n;
    logic mem_op;
    exp_t e;
    mem_op = (v.ld | v.st) & ~v.mis;
    @(negedge clock);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("v%0d_ready", idx), {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = v.ld; in_store = v.st; in_size = v.sz; in_unsigned = v.uns;
    in_addr = v.addr; in_store_data = v.sdata; in_opWrite = v.opw; in_opSel = 1'b0;
    in_opReg = v.rd;
    @(posedge clock);
    e.mdata = v.mdata; e.opw = v.opw & ~v.mis; e.mis = v.mis; e.alu = v.addr; e.rd = v.rd;
    sb_q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    if (mem_op) begin
      for (int k = 0; k <= v.gdly; k++) begin
        chk($sformatf("v%0d_mem_req", idx), {31'd0, mem_req}, 32'd1);
        chk($sformatf("v%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, v.st});
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_mem_be", idx), {28'd0, mem_be}, {28'd0, v.be});
        if (v.st) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
        if (k == v.gdly) mem_gnt = 1'b1;
        @(posedge clock);
        @(negedge clock);
        mem_gnt = 1'b0;
      end
      if (v.ld && !v.st) begin
        chk($sformatf("v%0d_req_drop", idx), {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(posedge clock);
        @(negedge clock);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end else begin
      chk($sformatf("v%0d_no_mem_req", idx), {31'd0, mem_req}, 32'd0);
    end
    chk($sformatf("v%0d_latency", idx), {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    chk($sformatf("v%0d_pulse", idx), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d_ready_after", idx), {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //           ld    st    sz     uns   addr        sdata         rdata        gd be       wdata         mdata         mis
    vecs[0]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 1, 4'b1000, 32'h0, 32'h00000080, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80112233, 0, 4'b1100, 32'h0, 32'hFFFF8011, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80118233, 0, 4'b0011, 32'h0, 32'h00008233, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h80112233, 2, 4'b0010, 32'h0, 32'h00000022, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h123456EF, 32'h0, 0, 4'b0010, 32'hEFEFEFEF, 32'h0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10C, 32'h11223344, 32'h0, 1, 4'b1111, 32'h11223344, 32'h0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
    vecs[10] = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h5555, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h055, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'hA5A5C3C3, 32'h0, 0, 4'b1111, 32'hA5A5C3C3, 32'h0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);

    reset = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'b00;
    in_unsigned = 1'b0; in_addr = '0; in_store_data = '0; in_opWrite = 1'b0; in_opSel = 1'b0;
    in_opReg = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opWrite", {31'd0, opWrite}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ALU_result", ALU_result, 32'd0);
    chk("rst_memory_data", memory_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) do_vec(vecs[i], i);

    // Back-to-back pass-through with in_valid held high.
    @(negedge clock);
    in_valid = 1'b1; in_load = 1'b0; in_store = 1'b0; in_size = 2'b10; in_opWrite = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_addr  = 32'h400 + i;
      in_opReg = i[4:0];
      if (in_ready) begin
        e.mdata = 32'h0; e.opw = 1'b1; e.mis = 1'b0; e.alu = in_addr; e.rd = i[4:0];
        sb_q.push_back(e);
      end
      @(posedge clock);
      @(negedge clock);
      chk("b2b_out_valid", {31'd0, out_valid}, {31'd0, (i % 2) == 0});
    end
    in_valid = 1'b0;

    // Reset while waiting for read data; the late rvalid must be ignored.
    @(negedge clock);
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'b10; in_addr = 32'h300;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("rw_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_gnt = 1'b0;
    chk("rw_in_wait", {31'd0, mem_req}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rw_ready_after_reset", {31'd0, in_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rw_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
    end

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: CORE, default 0, core index; DATA_WIDTH, default 32, datapath width; ADDR_WIDTH, default 32, byte address width.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  handshake from execute; transfer occurs when both are high at a rising edge.
REQ-005 in_load, in_store  in  1 each  operation is a load or a store; both low means pass-through.
REQ-006 in_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 in_unsigned  in  1  zero-extend the load when high.
REQ-008 in_addr  in  ADDR_WIDTH  byte address (the ALU result).
REQ-009 in_store_data  in  DATA_WIDTH  rs2 value.
REQ-010 in_opWrite, in_opSel, in_opReg  in  1, 1, 5  writeback controls.
REQ-011 mem_req, mem_we  out  1 each  data-memory request and write enable.
REQ-012 mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
REQ-013 mem_be  out  4  byte enables.
REQ-014 mem_wdata  out  DATA_WIDTH  lane-replicated store data.
REQ-015 mem_gnt, mem_rvalid  in  1 each  request accepted; read data valid.
REQ-016 mem_rdata  in  DATA_WIDTH  read data.
REQ-017 out_valid  out  1  one-cycle pulse marking a completed operation.
REQ-018 opWrite, opSel, opReg, ALU_result, memory_data  out  1, 1, 5, DATA_WIDTH, DATA_WIDTH  to writeback; ALU_result = in_addr.
REQ-019 misaligned  out  1  alignment fault; pulses with out_valid.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DONE; in_ready = 1 only in IDLE; one operation outstanding at a time.
REQ-021 On acceptance in IDLE, all inputs SHALL be captured and the FSM SHALL move to REQ for an aligned load or store, or to DONE for a pass-through or misaligned operation.
REQ-022 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; no mem_req is issued; misaligned=1 and opWrite=0 in DONE.
REQ-023 In REQ, mem_req=1 and mem_addr, mem_we, mem_be and mem_wdata SHALL be held stable until mem_gnt; on gnt a store goes to DONE and a load goes to WAIT.
REQ-024 In WAIT, mem_rvalid SHALL capture aligned mem_rdata and go to DONE; mem_rvalid outside WAIT is ignored.
REQ-025 Byte enables SHALL be: byte 0001<<addr[1:0]; half 0011 or 1100 by addr[1]; word 1111.
REQ-026 Store data SHALL be replicated: byte x4 lanes, half x2 lanes, word unchanged.
REQ-027 Load data SHALL select the lane by addr[1:0] and sign-extend unless in_unsigned; word loads pass unchanged.
REQ-028 DONE lasts exactly 1 cycle with out_valid=1, then the FSM returns to IDLE.
REQ-029 opWrite SHALL equal captured opWrite AND out_valid AND NOT misaligned, and SHALL be 0 in every other cycle.
REQ-030 memory_data SHALL be the aligned load data for loads and 0 otherwise; other outputs hold their last captured values.
REQ-031 Latency from the acceptance edge T: pass-through completes at T+1; a store with gnt in the first REQ cycle completes at T+2; a load with gnt at T+1 and rvalid at T+2 completes at T+3.
REQ-032 When in_load and in_store are both high, the operation SHALL be executed as a store.

Reset
REQ-033 Reset SHALL force IDLE, with mem_req, mem_we, out_valid, opWrite, misaligned = 0, all data/address outputs = 0, and in_ready = 1 in the following cycle.
REQ-034 Reset during REQ or WAIT SHALL abandon the operation with no out_valid; a late rvalid after reset SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-036 Load lane selection and extension SHALL be a combinational sub-module mem_load_align.

Verification
REQ-037 Test: LW addr 0x100, gnt at T+1, rvalid at T+2 with rdata 0xDEADBEEF -> out_valid at T+3, memory_data=0xDEADBEEF, opWrite=1.
REQ-038 Test: LB addr 0x103, rdata 0x80112233 -> memory_data=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-039 Test: SH addr 0x102, data 0x0000ABCD, gnt delayed 3 cycles -> mem_be=1100, mem_wdata=0xABCDABCD stable for all 4 REQ cycles, out_valid 1 cycle later.
REQ-040 Test: LW addr 0x101 -> no mem_req, out_valid and misaligned at T+1, opWrite=0.
REQ-041 Test: reset asserted in WAIT, then rvalid pulse -> no out_valid, FSM in IDLE, in_ready=1.
REQ-042 Test: back-to-back pass-through ops with in_valid held high -> one out_valid every 2 cycles, opWrite low between pulses.
